// File: rtl/msk_pkg.sv
// Shared constants and helpers for the masking front end.
// Share-bit indexing and randomness sizing live here so all users agree.
package msk_pkg;

  localparam int unsigned QDEPTH = 2;

  function automatic int unsigned share_idx(
    input int unsigned i,
    input int unsigned j,
    input int unsigned d
  );
    return i * d + j;
  endfunction

  function automatic int unsigned rnd_width(
    input int unsigned d,
    input int unsigned w
  );
    return (d - 1) * w;
  endfunction

endpackage

// File: rtl/msk_fifo2.sv
// Two-entry valid/ready queue with zeroize; popped slots are cleared
// so no stale sharing lingers in storage.
module msk_fifo2
  import msk_pkg::*;
#(
  parameter int unsigned P = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         zeroize,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [P-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_data
);

  logic [1:0]                  count_q, count_d;
  logic                        head_q, head_d;
  logic                        tail_q, tail_d;
  logic [QDEPTH-1:0][P-1:0]    mem_q, mem_d;
  logic                        push, pop;

  assign in_ready  = rst_n & ~zeroize & (count_q < 2'(QDEPTH));
  assign out_valid = rst_n & (count_q != 2'd0);
  assign out_data  = out_valid ? mem_q[head_q] : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    mem_d   = mem_q;
    if (pop) begin
      mem_d[head_q] = '0;
      head_d        = ~head_q;
    end
    if (push) begin
      mem_d[tail_q] = in_data;
      tail_d        = ~tail_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
    if (zeroize) begin
      count_d = '0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
      mem_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      mem_q   <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/msk_share_encoder.sv
// Turns plaintext words into D-share Boolean sharings using fresh
// randomness; share 0 is formed combinationally and stored masked only.
module msk_share_encoder
  import msk_pkg::*;
#(
  parameter  int unsigned D  = 2,
  parameter  int unsigned W  = 8,
  localparam int unsigned RW = rnd_width(D, W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           rnd_valid,
  output logic           rnd_ready,
  input  logic [RW-1:0]  rnd,
  input  logic           zeroize,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W*D-1:0] out_shares
);

  logic [W-1:0]   share0;
  logic [W*D-1:0] shares;
  logic           q_ready;

  always_comb begin
    share0 = in_data;
    for (int unsigned j = 1; j < D; j++)
      share0 = share0 ^ rnd[(j-1)*W +: W];
  end

  // Bit-interleave: bit i of share j lands at i*D+j.
  always_comb begin
    shares = '0;
    for (int unsigned i = 0; i < W; i++) begin
      shares[share_idx(i, 0, D)] = share0[i];
      for (int unsigned j = 1; j < D; j++)
        shares[share_idx(i, j, D)] = rnd[(j-1)*W + i];
    end
  end

  assign in_ready  = q_ready & rnd_valid;
  assign rnd_ready = q_ready & in_valid;

  msk_fifo2 #(
    .P (W*D)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .zeroize   (zeroize),
    .in_valid  (in_valid & rnd_valid),
    .in_ready  (q_ready),
    .in_data   (shares),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_shares)
  );

endmodule

// File: tb/tb_msk_share_encoder.sv
// Randomised and directed checks of msk_share_encoder against a
// queue-based model of the sharing stream.
module tb_msk_share_encoder;

  localparam int unsigned D  = 2;
  localparam int unsigned W  = 8;
  localparam int unsigned RW = (D-1)*W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           rnd_valid;
  logic           rnd_ready;
  logic [RW-1:0]  rnd;
  logic           zeroize;
  logic           out_valid;
  logic           out_ready;
  logic [W*D-1:0] out_shares;

  int n_chk = 0;
  int n_fail = 0;
  logic [W*D-1:0] mq[$];
  logic [W*D-1:0] got_q[$];
  logic [W*D-1:0] exp_q[$];

  always #5 clk = ~clk;

  msk_share_encoder #(.D(D), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .rnd        (rnd),
    .zeroize    (zeroize),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares)
  );

  function automatic logic [W*D-1:0] encode(
    input logic [W-1:0] p,
    input logic [RW-1:0] r
  );
    logic [W-1:0]   sh[D];
    logic [W*D-1:0] v;
    sh[0] = p;
    for (int j = 1; j < D; j++) begin
      sh[j] = r[(j-1)*W +: W];
      sh[0] = sh[0] ^ sh[j];
    end
    v = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < D; j++)
        v[i*D+j] = sh[j][i];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Compare all outputs against the model at the negedge.
  task automatic sample();
    logic room;
    @(negedge clk);
    room = rst_n && !zeroize && (mq.size() < 2);
    chk("in_ready", 64'(in_ready), 64'(room && rnd_valid));
    chk("rnd_ready", 64'(rnd_ready), 64'(room && in_valid));
    chk("out_valid", 64'(out_valid), 64'(rst_n && mq.size() != 0));
    chk("out_shares", 64'(out_shares),
        64'((rst_n && mq.size() != 0) ? mq[0] : '0));
  endtask

  task automatic advance();
    bit push, pop;
    @(posedge clk);
    if (!rst_n || zeroize) begin
      mq.delete();
    end else begin
      push = in_valid && rnd_valid && (mq.size() < 2);
      pop  = (mq.size() != 0) && out_ready;
      if (pop) got_q.push_back(mq.pop_front());
      if (push) mq.push_back(encode(in_data, rnd));
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drive(input bit iv, input logic [W-1:0] d,
                       input bit rv, input logic [RW-1:0] r,
                       input bit ordy);
    in_valid  = iv;
    in_data   = d;
    rnd_valid = rv;
    rnd       = r;
    out_ready = ordy;
  endtask

  initial begin
    int words;
    rst_n = 1'b0; zeroize = 1'b0;
    drive(1, 8'h11, 1, 16'h22, 1);
    advance();
    step();
    sample();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    advance();
    rst_n = 1'b1;

    // A5 masked by 3C
    drive(1, 8'hA5, 1, 8'h3C, 1);
    sample();
    chk("push_in_ready", 64'(in_ready), 64'd1);
    chk("push_rnd_ready", 64'(rnd_ready), 64'd1);
    advance();
    drive(0, 8'h00, 0, 8'h00, 0);
    sample();
    chk("lit_out_valid", 64'(out_valid), 64'd1);
    chk("lit_4BE1", 64'(out_shares), 64'h4BE1);
    chk("model_4BE1", 64'(encode(8'hA5, 8'h3C)), 64'h4BE1);
    advance();
    out_ready = 1;
    step();

    // data without randomness
    drive(1, 8'h5A, 0, 8'hFF, 1);
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("norand_in_ready", 64'(in_ready), 64'd0);
      chk("norand_rnd_ready", 64'(rnd_ready), 64'd1);
      chk("norand_out_valid", 64'(out_valid), 64'd0);
      advance();
    end
    rnd_valid = 1;
    step();
    drive(0, 8'h00, 0, 8'h00, 1);
    sample();
    chk("single_push", 64'(out_valid), 64'd1);
    advance();
    step();

    // back-pressure: third word stalls
    drive(1, 8'h01, 1, 8'hA0, 0);
    step();
    drive(1, 8'h02, 1, 8'hB0, 0);
    step();
    drive(1, 8'h03, 1, 8'hC0, 0);
    sample();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    advance();
    out_ready = 1;
    sample();
    chk("pop1_in_ready", 64'(in_ready), 64'd0);
    advance();
    sample();
    chk("pop2_in_ready", 64'(in_ready), 64'd1);
    advance();
    drive(0, 8'h00, 0, 8'h00, 1);
    for (int k = 0; k < 3; k++) step();
    exp_q = '{encode(8'h01, 8'hA0), encode(8'h02, 8'hB0),
              encode(8'h03, 8'hC0)};
    chk("order_cnt", 64'(got_q.size() >= 3), 64'd1);
    for (int k = 0; k < 3; k++)
      chk("order", 64'(got_q[got_q.size()-3+k]), 64'(exp_q[k]));

    // steady-state push and pop at count=1
    drive(1, 8'h40, 1, 8'h07, 0);
    step();
    got_q.delete();
    out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      in_data = W'(8'h41 + k);
      rnd = RW'($urandom);
      sample();
      chk("stream_out_valid", 64'(out_valid), 64'd1);
      advance();
    end
    chk("stream_words", 64'(got_q.size()), 64'd10);
    drive(0, 8'h00, 0, 8'h00, 1);
    step();
    step();

    // zeroize while full
    drive(1, 8'h0A, 1, 8'h0B, 0);
    step();
    step();
    zeroize = 1;
    sample();
    chk("zero_rnd_ready", 64'(rnd_ready), 64'd0);
    advance();
    zeroize = 0;
    in_valid = 0;
    sample();
    chk("zero_out_valid", 64'(out_valid), 64'd0);
    chk("zero_out_shares", 64'(out_shares), 64'd0);
    advance();

    // reset while full
    drive(1, 8'hC3, 1, 8'h96, 0);
    step();
    step();
    rst_n = 0;
    sample();
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_out_shares", 64'(out_shares), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd0);
    chk("mrst_rnd_ready", 64'(rnd_ready), 64'd0);
    advance();
    rst_n = 1;
    sample();
    chk("resume_in_ready", 64'(in_ready), 64'd1);
    advance();
    sample();
    chk("resume_out_valid", 64'(out_valid), 64'd1);
    advance();

    // randomised traffic
    words = 0;
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom),
            1'($urandom_range(0, 3) != 0), RW'($urandom),
            1'($urandom_range(0, 2) != 0));
      zeroize = ($urandom_range(0, 40) == 0);
      rst_n   = ($urandom_range(0, 80) != 0);
      if (in_ready) words++;
      step();
    end
    rst_n = 1; zeroize = 0;
    chk("rand_traffic", 64'(words > 100), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
